// File: rtl/alu_issue_ctrl.sv
// Issue controller that hands one request at a time to a registered ALU and
// returns its result, with the original tag, over a valid/ready response port.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_cout,
  output logic        rsp_overflow,
  output logic        rsp_err,
  output logic [3:0]  rsp_tag
);

  // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    CAPTURE = 3'd2,
    RESP    = 3'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        ready_en_reg;
  logic [31:0] src1_reg, src2_reg;
  logic [3:0]  ctrl_reg;
  logic        arith_reg;
  logic        accept;

  logic [3:0]  dec_ctrl;
  logic        dec_legal;
  logic        dec_arith;

  always_comb begin
    dec_ctrl  = 4'b0000;
    dec_legal = 1'b1;
    dec_arith = 1'b0;
    case (req_op)
      3'd0: begin dec_ctrl = 4'b0010; dec_arith = 1'b1; end
      3'd1: begin dec_ctrl = 4'b0110; dec_arith = 1'b1; end
      3'd2: dec_ctrl = 4'b0000;
      3'd3: dec_ctrl = 4'b0001;
      3'd4: dec_ctrl = 4'b1100;
      3'd5: dec_ctrl = 4'b1101;
      3'd6: dec_ctrl = 4'b0111;
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept = req_valid & req_ready;

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    alu_ctrl   = 4'b0000;
    case (state_reg)
      IDLE: begin
        req_ready = ready_en_reg;
        if (req_valid && ready_en_reg)
          state_next = dec_legal ? DRIVE : RESP;
      end
      DRIVE: begin
        alu_ctrl   = ctrl_reg;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        alu_ctrl   = ctrl_reg;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg    <= IDLE;
      ready_en_reg <= 1'b0;
      src1_reg     <= '0;
      src2_reg     <= '0;
      ctrl_reg     <= '0;
      arith_reg    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_tag      <= '0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      if (accept) begin
        rsp_tag <= req_tag;
        if (dec_legal) begin
          src1_reg  <= req_a;
          src2_reg  <= req_b;
          ctrl_reg  <= dec_ctrl;
          arith_reg <= dec_arith;
        end else begin
          // Illegal op answers immediately and leaves the ALU ports alone.
          rsp_result   <= '0;
          rsp_zero     <= 1'b0;
          rsp_cout     <= 1'b0;
          rsp_overflow <= 1'b0;
          rsp_err      <= 1'b1;
        end
      end
      if (state_reg == CAPTURE) begin
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_cout     <= arith_reg & alu_cout;
        rsp_overflow <= arith_reg & alu_overflow;
        rsp_err      <= 1'b0;
      end
    end
  end

  assign alu_src1 = src1_reg;
  assign alu_src2 = src2_reg;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-high.
REQ-003 req_valid  input  1  request present.
REQ-004 req_ready  output  1  controller accepts a request this cycle.
REQ-005 req_op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 NAND, 6 SLT, 7 illegal.
REQ-006 req_a, req_b  input  32 each  operands.
REQ-007 req_tag  input  4  requester tag, returned unchanged with the response.
REQ-008 alu_src1, alu_src2  output  32 each  operands to the ALU.
REQ-009 alu_ctrl  output  4  ALU control: [3] A_invert, [2] B_invert, [1:0] operation (00 AND, 01 OR, 10 add, 11 less).
REQ-010 alu_result  input  32; alu_zero, alu_cout, alu_overflow  input  1 each  registered ALU outputs, one-cycle latency.
REQ-011 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 rsp_result  output  32; rsp_zero, rsp_cout, rsp_overflow, rsp_err  output  1 each; rsp_tag  output  4.

Function
REQ-013 The block SHALL implement FSM states IDLE, DRIVE, CAPTURE and RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; a transfer occurs on an edge where req_valid and req_ready are both 1.
REQ-015 On a transfer with req_op 0-6, the block SHALL latch req_a, req_b, req_tag and the decoded control, then move IDLE->DRIVE.
REQ-016 The op decode SHALL be: ADD 0010, SUB 0110, AND 0000, OR 0001, NOR 1100, NAND 1101, SLT 0111.
REQ-017 alu_src1, alu_src2 and alu_ctrl SHALL be driven from the latched values and remain stable through DRIVE and CAPTURE.
REQ-018 DRIVE SHALL last exactly one cycle, then move to CAPTURE. The ALU registers its result at the end of DRIVE.
REQ-019 In CAPTURE, the block SHALL latch alu_result, alu_zero, alu_cout and alu_overflow into the rsp_* registers on the closing edge, then move to RESP.
REQ-020 For AND/OR/NOR/NAND/SLT, the block SHALL force rsp_cout and rsp_overflow to 0 regardless of the ALU inputs.
REQ-021 A transfer with req_op 7 SHALL skip DRIVE/CAPTURE and move IDLE->RESP with rsp_err=1, rsp_result=0, rsp_zero=0, rsp_cout=0, rsp_overflow=0 and the tag returned.
REQ-022 rsp_err SHALL be 0 for legal ops.
REQ-023 rsp_valid SHALL be 1 exactly in RESP.
REQ-024 rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-025 On an edge in RESP with rsp_ready=1, the block SHALL move to IDLE.
REQ-026 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest new acceptance is the following cycle.
REQ-027 Latency SHALL be 3 edges from acceptance to rsp_valid for legal ops (IDLE->DRIVE->CAPTURE->RESP), and 1 edge for illegal ops.
REQ-028 When idle, alu_ctrl SHALL be 0000 and alu_src1/alu_src2 SHALL hold their last values.
REQ-029 An illegal FSM encoding SHALL recover to IDLE on the next edge.

Reset
REQ-030 While rst_n=1, the FSM SHALL be IDLE and req_ready SHALL be 0.
REQ-031 While rst_n=1, rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err, rsp_tag, alu_src1, alu_src2 and alu_ctrl SHALL all be 0.
REQ-032 Reset asserted mid-operation (DRIVE, CAPTURE or RESP) SHALL abort the operation; no response SHALL be produced for it.
REQ-033 req_ready SHALL become 1 on the first edge after rst_n falls.

Verification
REQ-034 ADD a=0x7FFFFFFF b=0x00000001 tag=3 -> after 3 edges rsp_valid=1, result=0x80000000, overflow=1, cout=0, zero=0, tag=3.
REQ-035 SUB a=5 b=5 -> result=0, zero=1, cout=1, overflow=0; SLT a=0xFFFFFFFF b=1 -> result=1, cout=0, overflow=0.
REQ-036 NOR a=0 b=0 -> alu_ctrl=1100 observed in DRIVE, result=0xFFFFFFFF; NAND a=0xFFFFFFFF b=0xFFFFFFFF -> result=0, zero=1.
REQ-037 op=7 tag=9 -> rsp_valid after 1 edge, err=1, result=0, tag=9; ALU ports untouched (alu_ctrl stays 0000).
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0; rsp_ready=1 -> IDLE next edge, back-to-back request accepted the following cycle.
REQ-039 rst_n pulsed during CAPTURE -> all outputs 0 immediately, no response; next request completes normally.
